// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: PC register, single-outstanding imem request, IF/ID valid/ready.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault and halts fetch.
module fetch_unit #(
    parameter int unsigned  N        = 64,
    parameter logic [N-1:0] PC_RESET = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic         if_valid,
    input  logic         id_ready,
    output logic [31:0]  if_instr,
    output logic [10:0]  if_opcode,
    output logic [N-1:0] if_pc,
    input  logic         pc_src,
    input  logic [N-1:0] pc_branch,
    output logic         fetch_fault
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_LSB = 21;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_FULL  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t               state;
    logic   [N-1:0]       pc;
    logic   [N-1:0]       pc_req;
    logic                 fault_q;

    logic                 accept;
    logic                 in_flight;
    logic                 pending_after;
    logic                 bad_target;
    logic                 halted;
    logic   [N-1:0]       target;
    state_t               resume_state;
    state_t               redirect_state;

    assign accept    = (state == S_REQ) && imem_ready;
    assign in_flight = (state == S_WAIT) || (state == S_DRAIN);

    // A memory response is still owed after this edge, so a redirect must drain it first
    assign pending_after = accept || (in_flight && !imem_rvalid);

    assign target = {pc_branch[N-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign bad_target = (pc_branch[1:0] != 2'b00);
    assign halted     = fault_q;
`else
    logic unused_branch_low;
    assign unused_branch_low = ^pc_branch[1:0];
    assign bad_target        = 1'b0;
    assign halted            = 1'b0;
`endif

    always_comb begin
        resume_state   = halted ? S_IDLE : S_REQ;
        redirect_state = pending_after ? S_DRAIN : resume_state;
        if (bad_target) begin
            redirect_state = pending_after ? S_DRAIN : S_IDLE;
        end
    end

    // Fetch control: redirect takes priority over every handshake event on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pc       <= PC_RESET;
            pc_req   <= '0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            fault_q  <= 1'b0;
        end else if (pc_src) begin
            if_valid <= 1'b0;
            state    <= redirect_state;
            if (bad_target) begin
                fault_q <= 1'b1;
            end else begin
                pc <= target;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (!halted) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ready) begin
                        pc_req <= pc;
                        pc     <= pc + N'(4);
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc_req;
                        if_valid <= 1'b1;
                        state    <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (id_ready) begin
                        if_valid <= 1'b0;
                        state    <= resume_state;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state <= resume_state;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign if_opcode   = if_instr[INSTR_W-1:OPC_LSB];
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then randomized handshakes checked against a
// program-order model (next expected PC, one outstanding request, memory image by address).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [10:0] if_opcode;
    logic [63:0] if_pc;
    logic        pc_src;
    logic [63:0] pc_branch;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_req = 0;

    fetch_unit #(.N(64), .PC_RESET(64'h0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .id_ready    (id_ready),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_pc       (if_pc),
        .pc_src      (pc_src),
        .pc_branch   (pc_branch),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 64'(imem_req), 64'd1);
        last_req = cyc;
    endtask

    // Serve one request with the given response latency and check the presented instruction
    task automatic fetch_one(input logic [63:0] addr, input logic [31:0] word, input int lat);
        wait_req();
        chk("req_addr", imem_addr, addr);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("req_single", 64'(imem_req), 64'd0);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("early_valid", 64'(if_valid), 64'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
        chk("if_valid", 64'(if_valid), 64'd1);
        chk("if_pc", if_pc, addr);
        chk("if_instr", 64'(if_instr), 64'(word));
        chk("if_opcode", 64'(if_opcode), 64'(word[31:21]));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 64'(imem_req), 64'd0);
        chk({tag, "_addr"}, imem_addr, 64'h0);
        chk({tag, "_valid"}, 64'(if_valid), 64'd0);
        chk({tag, "_instr"}, 64'(if_instr), 64'd0);
        chk({tag, "_pc"}, if_pc, 64'h0);
        chk({tag, "_fault"}, 64'(fetch_fault), 64'd0);
    endtask

    initial begin
        int          t0;
        int          t1;
        int          consumed;
        int          pend_wait;
        logic        pend_valid;
        logic [63:0] pend_addr;
        logic [63:0] exp_pc;
        logic [31:0] w;

        reset_n     = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b0;
        pc_src      = 1'b0;
        pc_branch   = '0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Sequential fetch at one instruction per three cycles
        reset_n  = 1'b1;
        id_ready = 1'b1;
        tick();
        chk("first_req", 64'(imem_req), 64'd1);
        fetch_one(64'h0, 32'hF840_0020, 0);
        chk("ldur_opcode", 64'(if_opcode), 64'h7C2);
        t0 = last_req;
        fetch_one(64'h4, 32'hF840_0128, 0);
        t1 = last_req;
        chk("cadence_0_4", 64'(t1 - t0), 64'd3);
        fetch_one(64'h8, 32'h8B02_0020, 0);
        chk("cadence_4_8", 64'(last_req - t1), 64'd3);

        // Decoder stall holds the instruction
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 64'(if_valid), 64'd1);
            chk("stall_pc", if_pc, 64'h8);
            chk("stall_instr", 64'(if_instr), 64'h8B02_0020);
            chk("stall_noreq", 64'(imem_req), 64'd0);
        end
        id_ready = 1'b1;
        fetch_one(64'hC, 32'hCB03_0041, 1);

        // Redirect during WAIT, stale response arrives two cycles later
        wait_req();
        chk("pre_redir_addr", imem_addr, 64'h10);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        pc_src     = 1'b1;
        pc_branch  = 64'h100;
        tick();
        pc_src = 1'b0;
        chk("drain_valid", 64'(if_valid), 64'd0);
        chk("drain_noreq", 64'(imem_req), 64'd0);
        tick();
        chk("drain_noreq2", 64'(imem_req), 64'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("stale_dropped", 64'(if_valid), 64'd0);
        chk("redir_addr", imem_addr, 64'h100);
        id_ready = 1'b0;
        fetch_one(64'h100, 32'hB400_0040, 2);

        // Redirect in FULL while decoder is ready drops the held instruction
        id_ready  = 1'b1;
        pc_src    = 1'b1;
        pc_branch = 64'h200;
        tick();
        pc_src = 1'b0;
        chk("full_redir_valid", 64'(if_valid), 64'd0);
        chk("full_redir_req", 64'(imem_req), 64'd1);
        chk("full_redir_addr", imem_addr, 64'h200);

        // Redirect while REQ is not accepted, then PC wrap
        pc_src    = 1'b1;
        pc_branch = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        pc_src = 1'b0;
        chk("req_redir_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 32'h1400_0003, 0);
        wait_req();
        chk("wrap_addr", imem_addr, 64'h0);

        // Asynchronous reset in WAIT, late response ignored
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tick();
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        chk("late_rvalid_valid", 64'(if_valid), 64'd0);
        chk("post_rst_req", 64'(imem_req), 64'd1);
        chk("post_rst_addr", imem_addr, 64'h0);
        fetch_one(64'h0, 32'hF840_0020, 0);

        // Misaligned redirect target
        wait_req();
        pc_src    = 1'b1;
        pc_branch = 64'h102;
        tick();
        pc_src = 1'b0;
        chk("mis_valid", 64'(if_valid), 64'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", 64'(fetch_fault), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_noreq", 64'(imem_req), 64'd0);
            chk("halt_fault", 64'(fetch_fault), 64'd1);
        end
`else
        chk("mis_nofault", 64'(fetch_fault), 64'd0);
        chk("mis_req", 64'(imem_req), 64'd1);
        chk("mis_addr", imem_addr, 64'h100);
`endif
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("clear_fault", 64'(fetch_fault), 64'd0);

        // Randomized traffic against the program-order model
        exp_pc     = 64'h0;
        pend_valid = 1'b0;
        pend_addr  = '0;
        pend_wait  = 0;
        consumed   = 0;
        for (int c = 0; c < 3000; c++) begin
            imem_ready = ($urandom_range(0, 3) != 0);
            id_ready   = ($urandom_range(0, 2) != 0);
            pc_src     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) begin
                pc_branch = 64'hFFFF_FFFF_FFFF_FFF8;
            end else begin
                pc_branch = {$urandom, $urandom} & ~64'h3;
            end
            imem_rvalid = pend_valid && (pend_wait == 0);
            imem_rdata  = imem_rvalid ? mem_word(pend_addr) : $urandom;

            if (imem_req) begin
                chk("rnd_addr", imem_addr, exp_pc);
            end
            if (if_valid) begin
                w = mem_word(exp_pc);
                chk("rnd_if_pc", if_pc, exp_pc);
                chk("rnd_if_instr", 64'(if_instr), 64'(w));
                chk("rnd_if_opcode", 64'(if_opcode), 64'(w[31:21]));
            end
            chk("rnd_fault", 64'(fetch_fault), 64'd0);

            if (imem_rvalid) begin
                pend_valid = 1'b0;
            end else if (pend_valid) begin
                pend_wait--;
            end
            if (imem_req && imem_ready) begin
                chk("rnd_one_outstanding", 64'(pend_valid), 64'd0);
                pend_valid = 1'b1;
                pend_addr  = imem_addr;
                pend_wait  = int'($urandom_range(0, 2));
            end
            if (pc_src) begin
                exp_pc = pc_branch;
            end else if (if_valid && id_ready) begin
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end
            tick();
        end
        chk("rnd_progress", 64'(consumed > 50), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
